dmem_arbiter: RTL

- Shares the single data-memory port between two requesters: requester 0 is the CPU load/store stage, requester 1 is the debug/DMA loader.
- Round-robin ownership FSM with optional locked bursts and a forced-release limit.
- Drives the memory's clk-domain address, write-enable and write-data inputs, and steers read data back to the owner.
- Blocks requester-1 writes to the memory-mapped IO region (address bit 29).

---
 rtl/dmem_arb_pkg.sv | 16 +
 rtl/dmem_arb_rr_pick.sv | 14 +
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: state encoding, IO region
// default and lock counter sizing.
package dmem_arb_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    localparam int IO_ADDR_BIT_DEFAULT = 29;

    // Counter must be able to hold MAX_LOCK itself, since it saturates there.
    function automatic int lock_cnt_width(input int max_lock);
        return $clog2(max_lock + 1);
    endfunction

endpackage

// File: rtl/dmem_arb_rr_pick.sv
// Round-robin choice of the next owner; on a tie the requester that was not
// served last wins.
module dmem_arb_rr_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_served,
    output logic any,
    output logic pick
);

    assign any  = req0 | req1;
    assign pick = (req0 & req1) ? ~last_served : req1;

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: round-robin ownership with locked bursts,
// forced release, read-data steering and a requester-1 IO write guard.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_BIT_WIDTH = 32,
    parameter int DATA_BIT_WIDTH = 32,
    parameter int IO_ADDR_BIT    = IO_ADDR_BIT_DEFAULT,
    parameter int MAX_LOCK       = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req0,
    input  logic                      req1,
    input  logic                      lock0,
    input  logic                      lock1,
    input  logic [ADDR_BIT_WIDTH-1:0] addr0,
    input  logic [ADDR_BIT_WIDTH-1:0] addr1,
    input  logic                      wrtEn0,
    input  logic                      wrtEn1,
    input  logic [DATA_BIT_WIDTH-1:0] dIn0,
    input  logic [DATA_BIT_WIDTH-1:0] dIn1,
    output logic                      gnt0,
    output logic                      gnt1,
    output logic                      rvalid0,
    output logic                      rvalid1,
    output logic [DATA_BIT_WIDTH-1:0] rdata0,
    output logic [DATA_BIT_WIDTH-1:0] rdata1,
    output logic                      io_err,
    output logic [ADDR_BIT_WIDTH-1:0] mem_addr,
    output logic                      mem_wrtEn,
    output logic [DATA_BIT_WIDTH-1:0] mem_dIn,
    input  logic [DATA_BIT_WIDTH-1:0] mem_dOut,
    output logic [1:0]                fsm_state
);

    localparam int             LCW   = lock_cnt_width(MAX_LOCK);
    localparam logic [LCW:0]   MAX_W = (LCW + 1)'(MAX_LOCK);

    logic [1:0]     state;
    logic [1:0]     state_next;
    logic           last_served;
    logic           last_served_next;
    logic [LCW-1:0] lock_cnt;
    logic [LCW-1:0] lock_cnt_next;
    logic [LCW:0]   lock_inc;
    logic           release_now;
    logic           own_lock;
    logic           other_req;
    logic           beat;
    logic           io_block;
    logic           pick_any;
    logic           pick;

    assign gnt0      = (state == OWN0);
    assign gnt1      = (state == OWN1);
    assign fsm_state = state;

    assign own_lock  = gnt1 ? lock1 : lock0;
    assign other_req = gnt1 ? req0 : req1;
    assign beat      = (gnt0 & req0) | (gnt1 & req1);
    assign io_block  = gnt1 & req1 & wrtEn1 & addr1[IO_ADDR_BIT];

    // The owner's own request is masked so a release can only hand over to
    // the other side or fall back to IDLE.
    dmem_arb_rr_pick u_rr_pick (
        .req0        (req0 & ~gnt0),
        .req1        (req1 & ~gnt1),
        .last_served (last_served),
        .any         (pick_any),
        .pick        (pick)
    );

    always_comb begin
        state_next       = state;
        last_served_next = last_served;
        lock_cnt_next    = lock_cnt;
        release_now      = 1'b0;
        lock_inc         = {1'b0, lock_cnt} + (LCW + 1)'(1);
        case (state)
            IDLE: begin
                if (pick_any) state_next = pick ? OWN1 : OWN0;
            end
            OWN0, OWN1: begin
                if (!beat) begin
                    release_now = 1'b1;
                end else begin
                    lock_cnt_next = (lock_inc >= MAX_W) ? MAX_W[LCW-1:0] : lock_inc[LCW-1:0];
                    if (!own_lock || ((lock_inc >= MAX_W) && other_req)) begin
                        release_now      = 1'b1;
                        last_served_next = gnt1;
                    end
                end
                if (release_now) begin
                    lock_cnt_next = '0;
                    state_next    = pick_any ? (pick ? OWN1 : OWN0) : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_addr  = '0;
        mem_dIn   = '0;
        mem_wrtEn = 1'b0;
        if (gnt0) begin
            mem_addr  = addr0;
            mem_dIn   = dIn0;
            mem_wrtEn = wrtEn0 & req0;
        end else if (gnt1) begin
            mem_addr  = addr1;
            mem_dIn   = dIn1;
            mem_wrtEn = wrtEn1 & req1 & ~io_block;
        end
    end

    // Memory read data is already one cycle behind the address; rvalid marks it.
    assign rdata0 = mem_dOut;
    assign rdata1 = mem_dOut;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            last_served <= 1'b1;
            lock_cnt    <= '0;
            rvalid0     <= 1'b0;
            rvalid1     <= 1'b0;
            io_err      <= 1'b0;
        end else begin
            state       <= state_next;
            last_served <= last_served_next;
            lock_cnt    <= lock_cnt_next;
            rvalid0     <= gnt0 & req0 & ~wrtEn0;
            rvalid1     <= gnt1 & req1 & ~wrtEn1;
            io_err      <= io_block;
        end
    end

endmodule
